result_checker: RTL and testbench

Consumes the response stream that the device-under-test path writes into the result FIFO and compares it word by word against a parallel expected-data FIFO. It produces a pass/fail verdict, word and mismatch counts, and a record of the first mismatch. It sits directly downstream of the result FIFO, on the read side, and reports to the test sequencer.

---
 rtl/result_checker_if.sv | 22 ++
 rtl/result_checker.sv | 125 ++++++++++++
 tb/tb_result_checker.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_checker_if.sv
// Read-side bundle for the result FIFO and expected-data FIFO pair.
// The checker pops both heads together; the FIFOs present show-ahead data.
interface result_checker_if #(
   parameter int unsigned WIDTH = 24
);
   logic [WIDTH-1:0] rfifo_data;
   logic             rfifo_rdreq;
   logic             rfifo_rdempty;
   logic [WIDTH-1:0] efifo_data;
   logic             efifo_rdreq;
   logic             efifo_rdempty;

   modport master (
      input  rfifo_data, rfifo_rdempty, efifo_data, efifo_rdempty,
      output rfifo_rdreq, efifo_rdreq
   );

   modport slave (
      output rfifo_data, rfifo_rdempty, efifo_data, efifo_rdempty,
      input  rfifo_rdreq, efifo_rdreq
   );
endinterface

// File: rtl/result_checker.sv
// Compares the result FIFO stream against the expected FIFO word by word and
// reports a verdict, counts and the first mismatching word.
module result_checker #(
   parameter int unsigned RTF_WIDTH = 24,
   parameter int unsigned CNT_WIDTH = 16,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] test_len,
   input  logic [RTF_WIDTH-1:0] cmp_mask,
   result_checker_if.master     fifo,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic [CNT_WIDTH-1:0] word_cnt,
   output logic [CNT_WIDTH-1:0] err_cnt,
   output logic [CNT_WIDTH-1:0] first_err_idx,
   output logic [RTF_WIDTH-1:0] first_err_got,
   output logic [RTF_WIDTH-1:0] first_err_exp
);

   localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] len_q;
   logic [RTF_WIDTH-1:0] mask_q;
   logic [IDLE_W-1:0]    idle_q;

   logic pop_c;
   logic mismatch_c;
   logic launch_c;
   logic expire_c;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next state and per-cycle control
   always_comb begin
      state_d    = state_q;
      pop_c      = 1'b0;
      mismatch_c = 1'b0;
      launch_c   = 1'b0;
      expire_c   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               launch_c = 1'b1;
               state_d  = (test_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            pop_c      = ~fifo.rfifo_rdempty & ~fifo.efifo_rdempty;
            mismatch_c = pop_c & (|((fifo.rfifo_data ^ fifo.efifo_data) & mask_q));
            if (pop_c) begin
               if (word_cnt == len_q - CNT_WIDTH'(1)) state_d = S_DONE;
            end else if ((TIMEOUT != 0) && (idle_q == IDLE_LAST)) begin
               expire_c = 1'b1;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign fifo.rfifo_rdreq = pop_c;
   assign fifo.efifo_rdreq = pop_c;
   assign busy             = (state_q == S_RUN);
   assign done             = (state_q == S_DONE);
   assign pass             = done & (err_cnt == '0) & ~timeout;

   // Run configuration, counters and first-mismatch record
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         len_q         <= '0;
         mask_q        <= '0;
         idle_q        <= '0;
         timeout       <= 1'b0;
         word_cnt      <= '0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         first_err_got <= '0;
         first_err_exp <= '0;
      end else if (launch_c) begin
         len_q         <= test_len;
         mask_q        <= cmp_mask;
         idle_q        <= '0;
         timeout       <= 1'b0;
         word_cnt      <= '0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         first_err_got <= '0;
         first_err_exp <= '0;
      end else if (state_q == S_RUN) begin
         if (pop_c) begin
            idle_q   <= '0;
            word_cnt <= word_cnt + CNT_WIDTH'(1);
            if (mismatch_c) begin
               if (err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
               if (err_cnt == '0) begin
                  first_err_idx <= word_cnt;
                  first_err_got <= fifo.rfifo_data;
                  first_err_exp <= fifo.efifo_data;
               end
            end
         end else begin
            idle_q <= idle_q + IDLE_W'(1);
            if (expire_c) timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker with queue-based show-ahead FIFO models.
module tb_result_checker;

   localparam int unsigned W  = 24;
   localparam int unsigned C  = 16;
   localparam int unsigned TO = 8;

   logic         clock    = 1'b0;
   logic         reset_n  = 1'b0;
   logic         start    = 1'b0;
   logic [C-1:0] test_len = '0;
   logic [W-1:0] cmp_mask = '0;

   logic         busy, done, pass, timeout;
   logic [C-1:0] word_cnt, err_cnt, first_err_idx;
   logic [W-1:0] first_err_got, first_err_exp;

   result_checker_if #(.WIDTH(W)) fifo_if ();

   result_checker #(.RTF_WIDTH(W), .CNT_WIDTH(C), .TIMEOUT(TO)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .test_len      (test_len),
      .cmp_mask      (cmp_mask),
      .fifo          (fifo_if.master),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .timeout       (timeout),
      .word_cnt      (word_cnt),
      .err_cnt       (err_cnt),
      .first_err_idx (first_err_idx),
      .first_err_got (first_err_got),
      .first_err_exp (first_err_exp)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0] rq[$];
   logic [W-1:0] eq[$];
   int   cyc       = 0;
   int   rd_cycles = 0;
   int   last_rd   = -1;
   int   viol      = 0;
   logic pend_r    = 1'b0;
   logic pend_e    = 1'b0;
   logic throttle  = 1'b0;
   logic r_block   = 1'b0;

   always #5 clock = ~clock;

   // Mid-cycle monitor: log pops and protocol violations
   always @(negedge clock) begin
      cyc++;
      pend_r = fifo_if.rfifo_rdreq;
      pend_e = fifo_if.efifo_rdreq;
      if (pend_r !== pend_e) viol++;
      if (pend_r && fifo_if.rfifo_rdempty) viol++;
      if (pend_e && fifo_if.efifo_rdempty) viol++;
      if (pend_r) begin
         rd_cycles++;
         last_rd = cyc;
      end
   end

   // FIFO models: consume on the edge, then present the new heads
   always @(posedge clock) begin
      #1;
      if (pend_r && rq.size() != 0) void'(rq.pop_front());
      if (pend_e && eq.size() != 0) void'(eq.pop_front());
      r_block = throttle ? ~r_block : 1'b0;
      fifo_if.rfifo_rdempty = (rq.size() == 0) || r_block;
      fifo_if.rfifo_data    = (rq.size() != 0) ? rq[0] : '0;
      fifo_if.efifo_rdempty = (eq.size() == 0);
      fifo_if.efifo_data    = (eq.size() != 0) ? eq[0] : '0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input logic [C-1:0] len, input logic [W-1:0] mask);
      @(negedge clock); #1;
      start    = 1'b1;
      test_len = len;
      cmp_mask = mask;
      @(negedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clock); #1;
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: got %b expected 1 (timed out)", name, done);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      checks++; if (word_cnt !== 16'd0 || err_cnt !== 16'd0 || first_err_idx !== 16'd0) begin
         errors++; $display("FAIL reset_counts: got %0h/%0h/%0h expected 0/0/0", word_cnt, err_cnt, first_err_idx);
      end
      checks++; if (first_err_got !== 24'd0 || first_err_exp !== 24'd0) begin
         errors++; $display("FAIL reset_first_err: got %0h/%0h expected 0/0", first_err_got, first_err_exp);
      end
      checks++; if (fifo_if.rfifo_rdreq !== 1'b0 || fifo_if.efifo_rdreq !== 1'b0) begin
         errors++; $display("FAIL reset_rdreq: got %b%b expected 00", fifo_if.rfifo_rdreq, fifo_if.efifo_rdreq);
      end
      @(negedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_match();
      int rd0, v0, s;
      for (int i = 1; i <= 4; i++) begin
         rq.push_back(W'(i));
         eq.push_back(W'(i));
      end
      rd0 = rd_cycles; v0 = viol;
      do_start(16'd4, '1);
      s = cyc;
      wait_done("match");
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL match_pass: got %b expected 1", pass); end
      checks++; if (word_cnt !== 16'd4) begin errors++; $display("FAIL match_word_cnt: got %0d expected 4", word_cnt); end
      checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL match_err_cnt: got %0d expected 0", err_cnt); end
      checks++; if (rd_cycles - rd0 !== 4) begin errors++; $display("FAIL match_rdreq_count: got %0d expected 4", rd_cycles - rd0); end
      checks++; if (last_rd !== s + 3) begin errors++; $display("FAIL match_back_to_back: got last pop %0d expected %0d", last_rd, s + 3); end
      checks++; if (viol - v0 !== 0) begin errors++; $display("FAIL match_protocol: got %0d violations expected 0", viol - v0); end
   endtask

   task automatic test_mismatch();
      rq.push_back(24'hA); rq.push_back(24'hF); rq.push_back(24'hD);
      eq.push_back(24'hA); eq.push_back(24'hB); eq.push_back(24'hC);
      do_start(16'd3, '1);
      wait_done("mismatch");
      checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL mismatch_err_cnt: got %0d expected 2", err_cnt); end
      checks++; if (first_err_idx !== 16'd1) begin errors++; $display("FAIL mismatch_idx: got %0d expected 1", first_err_idx); end
      checks++; if (first_err_got !== 24'hF) begin errors++; $display("FAIL mismatch_got: got %0h expected f", first_err_got); end
      checks++; if (first_err_exp !== 24'hB) begin errors++; $display("FAIL mismatch_exp: got %0h expected b", first_err_exp); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mismatch_pass: got %b expected 0", pass); end
      checks++; if (word_cnt !== 16'd3) begin errors++; $display("FAIL mismatch_word_cnt: got %0d expected 3", word_cnt); end
   endtask

   task automatic test_mask();
      rq.push_back(24'h1200FF); eq.push_back(24'h0000FF);
      do_start(16'd1, 24'h00FFFF);
      wait_done("mask_partial");
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL mask_partial_pass: got %b expected 1", pass); end
      checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL mask_partial_err: got %0d expected 0", err_cnt); end
      // Single-word run: final pop and first mismatch land on the same edge
      rq.push_back(24'h1200FF); eq.push_back(24'h0000FF);
      do_start(16'd1, '1);
      wait_done("mask_full");
      checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL mask_full_err: got %0d expected 1", err_cnt); end
      checks++; if (first_err_idx !== 16'd0) begin errors++; $display("FAIL mask_full_idx: got %0d expected 0", first_err_idx); end
      checks++; if (first_err_got !== 24'h1200FF) begin errors++; $display("FAIL mask_full_got: got %0h expected 1200ff", first_err_got); end
      checks++; if (first_err_exp !== 24'h0000FF) begin errors++; $display("FAIL mask_full_exp: got %0h expected ff", first_err_exp); end
      checks++; if (pass !== 1'b0 || word_cnt !== 16'd1) begin
         errors++; $display("FAIL mask_full_verdict: got pass=%b words=%0d expected pass=0 words=1", pass, word_cnt);
      end
   endtask

   task automatic test_timeout();
      rq.push_back(24'h55); eq.push_back(24'h55);
      do_start(16'd2, '1);
      wait_done("timeout");
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", timeout); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL timeout_pass: got %b expected 0", pass); end
      checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL timeout_word_cnt: got %0d expected 1", word_cnt); end
      checks++; if (cyc - last_rd !== 9) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected 9", cyc - last_rd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
   endtask

   task automatic test_len_zero();
      int rd0;
      rq.push_back(24'h1); rq.push_back(24'h2);
      eq.push_back(24'h1); eq.push_back(24'h2);
      rd0 = rd_cycles;
      do_start(16'd0, '1);
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin
         errors++; $display("FAIL len0_verdict: got done=%b pass=%b expected done=1 pass=1", done, pass);
      end
      checks++; if (timeout !== 1'b0 || err_cnt !== 16'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL len0_state: got timeout=%b err=%0d busy=%b expected 0/0/0", timeout, err_cnt, busy);
      end
      repeat (3) @(negedge clock);
      #1;
      checks++; if (rd_cycles - rd0 !== 0) begin errors++; $display("FAIL len0_no_rdreq: got %0d pops expected 0", rd_cycles - rd0); end
      checks++; if (rq.size() !== 2 || eq.size() !== 2) begin
         errors++; $display("FAIL len0_fifo_untouched: got %0d/%0d words expected 2/2", rq.size(), eq.size());
      end
      rq.delete(); eq.delete();
   endtask

   task automatic test_throttle();
      int rd0, v0;
      throttle = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rq.push_back(W'(i * 3 + 7));
         eq.push_back(W'(i * 3 + 7));
      end
      rd0 = rd_cycles; v0 = viol;
      do_start(16'd6, '1);
      wait_done("throttle");
      throttle = 1'b0;
      checks++; if (viol - v0 !== 0) begin errors++; $display("FAIL throttle_protocol: got %0d violations expected 0", viol - v0); end
      checks++; if (rd_cycles - rd0 !== 6) begin errors++; $display("FAIL throttle_pops: got %0d expected 6", rd_cycles - rd0); end
      checks++; if (word_cnt !== 16'd6 || err_cnt !== 16'd0) begin
         errors++; $display("FAIL throttle_counts: got %0d/%0d expected 6/0", word_cnt, err_cnt);
      end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL throttle_pass: got %b expected 1", pass); end
      checks++; if (rq.size() !== 0 || eq.size() !== 0) begin
         errors++; $display("FAIL throttle_drained: got %0d/%0d words expected 0/0", rq.size(), eq.size());
      end
   endtask

   task automatic test_start_during_run();
      do_start(16'd3, '1);
      do_start(16'd1, 24'h0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_start_busy: got %b expected 1", busy); end
      rq.push_back(24'h10); rq.push_back(24'h20); rq.push_back(24'h31);
      eq.push_back(24'h10); eq.push_back(24'h20); eq.push_back(24'h30);
      wait_done("run_start");
      checks++; if (word_cnt !== 16'd3) begin errors++; $display("FAIL run_start_word_cnt: got %0d expected 3", word_cnt); end
      checks++; if (err_cnt !== 16'd1 || first_err_idx !== 16'd2) begin
         errors++; $display("FAIL run_start_err: got err=%0d idx=%0d expected err=1 idx=2", err_cnt, first_err_idx);
      end
   endtask

   task automatic test_reset_mid_run();
      rq.push_back(24'h99); rq.push_back(24'h2); rq.push_back(24'h3); rq.push_back(24'h4);
      eq.push_back(24'h11); eq.push_back(24'h2); eq.push_back(24'h3); eq.push_back(24'h4);
      do_start(16'd5, '1);
      @(negedge clock); #1;
      checks++; if (busy !== 1'b1 || err_cnt !== 16'd1 || fifo_if.rfifo_rdreq !== 1'b1) begin
         errors++; $display("FAIL midrun_pre: got busy=%b err=%0d rdreq=%b expected 1/1/1", busy, err_cnt, fifo_if.rfifo_rdreq);
      end
      reset_n = 1'b0;
      #1;
      checks++; if (fifo_if.rfifo_rdreq !== 1'b0 || fifo_if.efifo_rdreq !== 1'b0) begin
         errors++; $display("FAIL midrun_rdreq: got %b%b expected 00", fifo_if.rfifo_rdreq, fifo_if.efifo_rdreq);
      end
      checks++; if (busy !== 1'b0 || word_cnt !== 16'd0 || err_cnt !== 16'd0) begin
         errors++; $display("FAIL midrun_outputs: got busy=%b words=%0d err=%0d expected 0/0/0", busy, word_cnt, err_cnt);
      end
      checks++; if (first_err_got !== 24'd0 || first_err_exp !== 24'd0) begin
         errors++; $display("FAIL midrun_first_err: got %0h/%0h expected 0/0", first_err_got, first_err_exp);
      end
      @(negedge clock); #1;
      reset_n = 1'b1;
      rq.delete(); eq.delete();
      rq.push_back(24'hABCDEF); rq.push_back(24'h123456);
      eq.push_back(24'hABCDEF); eq.push_back(24'h123456);
      do_start(16'd2, '1);
      wait_done("restart");
      checks++; if (pass !== 1'b1 || word_cnt !== 16'd2 || err_cnt !== 16'd0) begin
         errors++; $display("FAIL restart_verdict: got pass=%b words=%0d err=%0d expected 1/2/0", pass, word_cnt, err_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_mask();
      test_timeout();
      test_len_zero();
      test_throttle();
      test_start_during_run();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
